seven_seg_scan_driver: RTL and testbench

Multi-digit, time-multiplexed seven-segment driver for the board's display bank. Takes an unsigned binary value, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, saturates values that do not fit, and scans the digits one at a time. Each digit uses the team's 8-bit segment encoding. Sits between the spectrum/readout logic and the display pins.

---
 rtl/seven_seg_scan_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: binary value -> saturated BCD (sequential double-dabble)
// -> time-multiplexed seven-segment scan, one digit enabled at a time.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).

module seven_seg_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned BIN_W    = 14,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value_in,
    input  logic              load,
    output logic              busy,
    output logic [DIGITS-1:0] digit_sel,
    output logic [7:0]        display
);

    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Largest displayable decimal value, 10^n - 1
    function automatic logic [63:0] pow10_m1(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC  = pow10_m1(DIGITS);
    localparam bit          NEED_SAT = (BIN_W >= 64) ? 1'b1
                                     : (((64'd1 << BIN_W) - 64'd1) > MAX_DEC);

    // Fixed board segment encoding; non-decimal nibbles are blank
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'b11101011;
            4'd1:    seg = 8'b00101000;
            4'd2:    seg = 8'b10110011;
            4'd3:    seg = 8'b10111010;
            4'd4:    seg = 8'b01111000;
            4'd5:    seg = 8'b11011010;
            4'd6:    seg = 8'b11011011;
            4'd7:    seg = 8'b10101000;
            4'd8:    seg = 8'b11111011;
            4'd9:    seg = 8'b11111010;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_capture;
    logic                w_step;
    logic                w_final;

    logic [BIN_W-1:0]    r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [CNT_W-1:0]    r_step_cnt;
    logic [BCD_W-1:0]    r_shown;
    logic                r_busy;

    logic [BIN_W-1:0]    w_cap_value;
    logic [BCD_W-1:0]    w_bcd_adj;
    logic [BCD_W-1:0]    w_bcd_step;
    logic [BIN_W-1:0]    w_bin_step;
    logic [BCD_W-1:0]    w_shown_next;

    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_digit_sel;
    logic [7:0]          r_display;

    logic                w_presc_tc;
    logic [PRESC_W-1:0]  w_presc_next;
    logic [IDX_W-1:0]    w_idx_next;
    logic [DIGITS-1:0]   w_blank_mask;
    logic [3:0]          w_nibble_sel;
    logic                w_blank_sel;

    // Clamp out-of-range inputs to all nines so the BCD scratch never overflows
    generate
        if (NEED_SAT) begin : g_sat
            localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(MAX_DEC);
            assign w_cap_value = (value_in > SAT_VAL) ? SAT_VAL : value_in;
        end else begin : g_no_sat
            assign w_cap_value = value_in;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (load) w_state_next = S_CONV;
            S_CONV: if (r_step_cnt == CNT_W'(BIN_W - 1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM control decode: capture in IDLE, one shift-add-3 step per CONV cycle
    always_comb begin
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_final   = 1'b0;
        case (r_state)
            S_IDLE: w_capture = load;
            S_CONV: begin
                w_step  = 1'b1;
                w_final = (r_step_cnt == CNT_W'(BIN_W - 1));
            end
            default: ;
        endcase
    end

    // Add 3 to every BCD nibble >= 5 ahead of the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_step   = (w_bcd_adj << 1) | BCD_W'(r_bin[BIN_W-1]);
    assign w_bin_step   = r_bin << 1;
    assign w_shown_next = w_final ? w_bcd_step : r_shown;

    // Conversion datapath; shown digits only change on the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_step_cnt <= '0;
            r_shown    <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_bin      <= w_cap_value;
                r_bcd      <= '0;
                r_step_cnt <= '0;
            end else if (w_step) begin
                r_bin      <= w_bin_step;
                r_bcd      <= w_bcd_step;
                r_step_cnt <= r_step_cnt + CNT_W'(1);
            end
            r_shown <= w_shown_next;
            r_busy  <= (w_state_next == S_CONV);
        end
    end

    // Free-running prescaler and digit index
    always_comb begin
        w_presc_tc   = (r_presc == PRESC_W'(SCAN_DIV - 1));
        w_presc_next = w_presc_tc ? '0 : (r_presc + PRESC_W'(1));
        w_idx_next   = r_idx;
        if (w_presc_tc) begin
            w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : (r_idx + IDX_W'(1));
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a digit when it and everything above it is zero; digit 0 always shown
    always_comb begin
        logic zero_run;
        zero_run     = 1'b1;
        w_blank_mask = '0;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            zero_run        = zero_run && (w_shown_next[4*d +: 4] == 4'd0);
            w_blank_mask[d] = zero_run && (d != 0);
        end
    end
`else
    assign w_blank_mask = '0;
`endif

    // Pick the nibble and blank flag for the digit about to be enabled
    always_comb begin
        w_nibble_sel = 4'd0;
        w_blank_sel  = 1'b0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (w_idx_next == IDX_W'(d)) begin
                w_nibble_sel = w_shown_next[4*d +: 4];
                w_blank_sel  = w_blank_mask[d];
            end
        end
    end

    // Scan registers; digit_sel and display update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_digit_sel <= DIGITS'(1);
            r_display   <= 8'b11101011;
        end else begin
            r_presc     <= w_presc_next;
            r_idx       <= w_idx_next;
            r_digit_sel <= DIGITS'(1) << w_idx_next;
            r_display   <= w_blank_sel ? 8'h00 : seg_encode(w_nibble_sel);
        end
    end

    assign busy      = r_busy;
    assign digit_sel = r_digit_sel;
    assign display   = r_display;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (DIGITS=4, BIN_W=14, SCAN_DIV=4).
// Honors LEADING_ZERO_BLANK_EN when expecting leading-zero digits.

module tb_seven_seg_scan_driver;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned BIN_W    = 14;
    localparam int unsigned SCAN_DIV = 4;

    localparam logic [7:0] SEG0 = 8'b11101011;
    localparam logic [7:0] SEG1 = 8'b00101000;
    localparam logic [7:0] SEG2 = 8'b10110011;
    localparam logic [7:0] SEG3 = 8'b10111010;
    localparam logic [7:0] SEG4 = 8'b01111000;
    localparam logic [7:0] SEG8 = 8'b11111011;
    localparam logic [7:0] SEG9 = 8'b11111010;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ   = 8'h00;
`else
    localparam logic [7:0] LZ   = SEG0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [BIN_W-1:0]  value_in;
    logic              load;
    logic              busy;
    logic [DIGITS-1:0] digit_sel;
    logic [7:0]        display;

    int checks   = 0;
    int failures = 0;
    int width;

    seven_seg_scan_driver #(
        .DIGITS   (DIGITS),
        .BIN_W    (BIN_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .load      (load),
        .busy      (busy),
        .digit_sel (digit_sel),
        .display   (display)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk digits 0..3 in scan order and compare each segment pattern
    task automatic read_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                               input logic [7:0] e1, input logic [7:0] e0);
        logic [7:0] exp_seg [4];
        exp_seg = '{e0, e1, e2, e3};
        for (int d = 0; d < 4; d++) begin
            int n;
            n = 0;
            while (digit_sel !== 4'(1 << d) && n < 40) begin
                tick();
                n++;
            end
            check($sformatf("%s_sel%0d", tag, d), 32'(digit_sel), 32'(1 << d));
            check($sformatf("%s_dig%0d", tag, d), 32'(display), 32'(exp_seg[d]));
        end
    endtask

    // Pulse load, then count busy cycles; optionally fire a load mid-conversion
    task automatic convert(input logic [BIN_W-1:0] v, input int ign_at,
                           input logic [BIN_W-1:0] ign_v, output int busy_w);
        value_in = v;
        load     = 1'b1;
        tick();
        load   = 1'b0;
        busy_w = 0;
        while (busy === 1'b1 && busy_w < 40) begin
            busy_w++;
            if (busy_w == ign_at) begin
                load     = 1'b1;
                value_in = ign_v;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value_in = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel",  32'(digit_sel), 32'h1);
        check("rst_disp", 32'(display), 32'(SEG0));

        for (int k = 1; k <= 4; k++) begin
            repeat (SCAN_DIV) tick();
            check($sformatf("scan_step%0d", k), 32'(digit_sel), 32'(1 << (k % 4)));
        end

        convert(14'd1234, -1, '0, width);
        check("w1234", 32'(width), 32'd14);
        read_digits("v1234", SEG1, SEG2, SEG3, SEG4);

        convert(14'd12000, 3, 14'd5, width);
        check("wsat", 32'(width), 32'd14);
        read_digits("sat", SEG9, SEG9, SEG9, SEG9);

        convert(14'd7, -1, '0, width);
        check("w7", 32'(width), 32'd14);
        convert(14'd8, -1, '0, width);
        check("b2b_w8", 32'(width), 32'd14);
        read_digits("b2b", LZ, LZ, LZ, SEG8);

        value_in = 14'd4321;
        load     = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_sel",  32'(digit_sel), 32'h1);
        check("mid_disp", 32'(display), 32'(SEG0));
        repeat (20) tick();
        check("mid_idle", 32'(busy), 32'd0);
        read_digits("mid", LZ, LZ, LZ, SEG0);

        convert(14'd42, -1, '0, width);
        check("w42", 32'(width), 32'd14);
        read_digits("v42", LZ, LZ, SEG4, SEG2);

        convert(14'd0, -1, '0, width);
        check("w0", 32'(width), 32'd14);
        read_digits("v0", LZ, LZ, LZ, SEG0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
